little_window_sequencer: RTL

//  Frame-synchronous controller for the little-window test-pattern generator. Holds a table of window

---
 rtl/little_window_sequencer_pkg.sv | 49 ++++
 rtl/little_window_sequencer_if.sv | 45 ++++
 rtl/little_window_sequencer_clamp.sv | 29 ++
 rtl/little_window_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/little_window_sequencer_pkg.sv
// Shared types, table geometry and raster limits for the little-window sequencer.
// The clamp helper trims one axis (position/length) against a raster limit.
package little_window_sequencer_pkg;

  localparam int LW_DEPTH   = 8;
  localparam int LW_IDX_W   = 3;
  localparam int LW_FRAME_W = 8;
  localparam int LW_MAX_H   = 1920;
  localparam int LW_MAX_V   = 1080;

  typedef struct packed {
    logic [11:0] top;
    logic [11:0] left;
    logic [11:0] width;
    logic [11:0] height;
  } win_cfg_t;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    DRAIN
  } seq_state_e;

  // Returns {pos, len}; 13-bit sums so that pos+len never wraps before comparison.
  function automatic logic [23:0] clamp_axis(input logic [11:0] pos,
                                             input logic [11:0] len,
                                             input logic [12:0] limit);
    logic [12:0] pos13;
    logic [12:0] end13;
    logic [11:0] p;
    logic [11:0] l;
    pos13 = {1'b0, pos};
    end13 = pos13 + {1'b0, len};
    p     = pos;
    l     = len;
    if (pos13 >= limit) begin
      p = 12'(limit - 13'd1);
      l = 12'd1;
    end else if (end13 > limit) begin
      l = 12'(limit - pos13);
    end
    if (l == 12'd0) begin
      l = 12'd1;
    end
    return {p, l};
  endfunction

endpackage

// File: rtl/little_window_sequencer_if.sv
// Register-side control, table writes and generator-side outputs of the sequencer.
// master = CPU/register side, slave = the sequencer itself.
interface little_window_sequencer_if
  import little_window_sequencer_pkg::*;
#(
  parameter int IDX_W   = LW_IDX_W,
  parameter int FRAME_W = LW_FRAME_W
);

  logic               start;
  logic               stop;
  logic               single;
  logic [FRAME_W-1:0] frames_per_win;
  logic [IDX_W:0]     num_win;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_addr;
  logic [11:0]        wr_top;
  logic [11:0]        wr_left;
  logic [11:0]        wr_width;
  logic [11:0]        wr_height;
  logic               vsync;

  logic               enable;
  logic [11:0]        top;
  logic [11:0]        left;
  logic [11:0]        width;
  logic [11:0]        height;
  logic [IDX_W-1:0]   win_idx;
  logic               busy;
  logic               done;
  logic               cfg_err;

  modport master (
    output start, stop, single, frames_per_win, num_win,
    output wr_en, wr_addr, wr_top, wr_left, wr_width, wr_height, vsync,
    input  enable, top, left, width, height, win_idx, busy, done, cfg_err
  );

  modport slave (
    input  start, stop, single, frames_per_win, num_win,
    input  wr_en, wr_addr, wr_top, wr_left, wr_width, wr_height, vsync,
    output enable, top, left, width, height, win_idx, busy, done, cfg_err
  );

endinterface

// File: rtl/little_window_sequencer_clamp.sv
// Combinational clamp of one window entry to the raster; flags whether any field changed.
module little_window_sequencer_clamp
  import little_window_sequencer_pkg::*;
#(
  parameter int MAX_H = LW_MAX_H,
  parameter int MAX_V = LW_MAX_V
) (
  input  win_cfg_t cfg_in,
  output win_cfg_t cfg_out,
  output logic     clamped
);

  localparam logic [12:0] LIM_H = 13'(MAX_H);
  localparam logic [12:0] LIM_V = 13'(MAX_V);

  logic [23:0] h_axis;
  logic [23:0] v_axis;

  always_comb begin
    h_axis         = clamp_axis(cfg_in.left, cfg_in.width, LIM_H);
    v_axis         = clamp_axis(cfg_in.top, cfg_in.height, LIM_V);
    cfg_out.left   = h_axis[23:12];
    cfg_out.width  = h_axis[11:0];
    cfg_out.top    = v_axis[23:12];
    cfg_out.height = v_axis[11:0];
    clamped        = (cfg_out != cfg_in);
  end

endmodule

// File: rtl/little_window_sequencer.sv
// Frame-synchronous window sequencer: steps through a table of window configs and
// only changes the generator coefficients on a vsync rising edge.
module little_window_sequencer
  import little_window_sequencer_pkg::*;
#(
  parameter int DEPTH   = LW_DEPTH,
  parameter int IDX_W   = LW_IDX_W,
  parameter int FRAME_W = LW_FRAME_W,
  parameter int MAX_H   = LW_MAX_H,
  parameter int MAX_V   = LW_MAX_V
) (
  input logic                      pclk,
  input logic                      prst,
  little_window_sequencer_if.slave bus
);

  localparam logic [IDX_W:0] NUM_MAX = (IDX_W+1)'(DEPTH);

  seq_state_e         state;
  seq_state_e         state_n;
  win_cfg_t           win_tab [DEPTH];
  win_cfg_t           wr_cfg;
  win_cfg_t           load_src;
  win_cfg_t           load_cfg;
  win_cfg_t           cfg_q;
  logic               load_clamped;

  logic               vs_d;
  logic               vs_rise;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_n;
  logic [IDX_W-1:0]   load_idx;
  logic [FRAME_W-1:0] cnt_q;
  logic [FRAME_W-1:0] cnt_n;
  logic [FRAME_W-1:0] fpw_q;
  logic [IDX_W:0]     num_q;
  logic               single_q;
  logic               enable_q;
  logic               enable_n;
  logic               done_q;
  logic               done_n;
  logic               cfg_err_q;
  logic               cfg_err_n;
  logic               reject_req;
  logic               load;
  logic               latch_cfg;
  logic               start_bad;
  logic               last_win;
  logic               last_frame;

  assign vs_rise    = bus.vsync & ~vs_d;
  assign wr_cfg     = '{top: bus.wr_top, left: bus.wr_left,
                        width: bus.wr_width, height: bus.wr_height};
  assign start_bad  = (bus.num_win == '0) || (bus.num_win > NUM_MAX) ||
                      (bus.frames_per_win == '0);
  assign last_win   = ({1'b0, idx_q} == (num_q - (IDX_W+1)'(1)));
  assign last_frame = (cnt_q == (fpw_q - FRAME_W'(1)));

  // A write landing on the entry being loaded in the same cycle wins over the stored copy.
  assign load_src = (bus.wr_en && (bus.wr_addr == load_idx)) ? wr_cfg : win_tab[load_idx];

  little_window_sequencer_clamp #(
    .MAX_H (MAX_H),
    .MAX_V (MAX_V)
  ) u_clamp (
    .cfg_in  (load_src),
    .cfg_out (load_cfg),
    .clamped (load_clamped)
  );

  assign cfg_err_n = reject_req | (load & load_clamped);

  always_ff @(posedge pclk) begin
    if (prst) begin
      for (int i = 0; i < DEPTH; i++) begin
        win_tab[i] <= '0;
      end
    end else if (bus.wr_en) begin
      win_tab[bus.wr_addr] <= wr_cfg;
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state     <= IDLE;
      vs_d      <= 1'b0;
      enable_q  <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      fpw_q     <= '0;
      num_q     <= '0;
      single_q  <= 1'b0;
      cfg_q     <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      vs_d      <= bus.vsync;
      enable_q  <= enable_n;
      idx_q     <= idx_n;
      cnt_q     <= cnt_n;
      done_q    <= done_n;
      cfg_err_q <= cfg_err_n;
      if (latch_cfg) begin
        fpw_q    <= bus.frames_per_win;
        num_q    <= bus.num_win;
        single_q <= bus.single;
      end
      if (load) begin
        cfg_q <= load_cfg;
      end
    end
  end

  // stop takes priority over a coincident vsync edge: the current window is not advanced.
  always_comb begin
    state_n    = state;
    enable_n   = enable_q;
    idx_n      = idx_q;
    cnt_n      = cnt_q;
    done_n     = 1'b0;
    reject_req = 1'b0;
    load       = 1'b0;
    load_idx   = '0;
    latch_cfg  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          if (start_bad) begin
            reject_req = 1'b1;
          end else begin
            latch_cfg = 1'b1;
            state_n   = ARM;
          end
        end
      end
      ARM: begin
        if (bus.stop) begin
          state_n = DRAIN;
        end else if (vs_rise) begin
          load     = 1'b1;
          load_idx = '0;
          enable_n = 1'b1;
          idx_n    = '0;
          cnt_n    = '0;
          state_n  = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_n = DRAIN;
        end else if (vs_rise) begin
          if (last_frame) begin
            cnt_n = '0;
            if (last_win && single_q) begin
              enable_n = 1'b0;
              done_n   = 1'b1;
              state_n  = IDLE;
            end else if (last_win) begin
              idx_n    = '0;
              load     = 1'b1;
              load_idx = '0;
            end else begin
              idx_n    = idx_q + IDX_W'(1);
              load     = 1'b1;
              load_idx = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_n = cnt_q + FRAME_W'(1);
          end
        end
      end
      DRAIN: begin
        if (vs_rise) begin
          enable_n = 1'b0;
          done_n   = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.enable  = enable_q;
  assign bus.top     = cfg_q.top;
  assign bus.left    = cfg_q.left;
  assign bus.width   = cfg_q.width;
  assign bus.height  = cfg_q.height;
  assign bus.win_idx = idx_q;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.cfg_err = cfg_err_q;

endmodule
